// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder: one outstanding load/store, LATENCY wait
// states, a single-cycle response with read data, a range error and an error count.
module dmem_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [7:0]        err_count
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [7:0]          err_count_q, err_count_d;

  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;
  logic                oor_q, oor_d;

  logic [DATA_W-1:0]   mem [2**ADDR_W];

  logic                accept;
  logic                access;
  logic                mem_we;

  function automatic logic out_of_range(input logic [31:0] a);
    return |a[31:ADDR_W];
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // Acceptance needs the registered ready, so nothing is taken in the reset-release cycle.
  assign accept = (state_q == IDLE) && req_ready_q && req_valid;
  assign access = (state_q == WAIT) && (cnt_q == 4'd0);
  assign mem_we = access && write_q && !oor_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      err_count_q <= err_count_d;
    end
  end

  // Request capture registers hold only data and are qualified by the state machine.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    write_q <= write_d;
    oor_q   <= oor_d;
  end

  // Storage is deliberately not reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
          cnt_d   = 4'(LATENCY);
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = access;
    rsp_err_d   = access && oor_q;
    rsp_rdata_d = (access && !write_q && !oor_q) ? mem[addr_q] : '0;
    err_count_d = (access && oor_q) ? sat_inc(err_count_q) : err_count_q;
    addr_d      = accept ? req_addr[ADDR_W-1:0] : addr_q;
    wdata_d     = accept ? req_wdata : wdata_q;
    write_d     = accept ? req_write : write_q;
    oor_d       = accept ? out_of_range(req_addr) : oor_q;
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: queued expectations from a memory/counter
// model, a negedge monitor, plus a LATENCY=0 instance for back-to-back timing.
module tb_dmem_responder;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0, req_write = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [7:0]    err_count;

  logic          v0 = 1'b0, w0 = 1'b0;
  logic [31:0]   a0 = '0;
  logic [DW-1:0] d0 = '0;
  logic          r0, rv0, re0;
  logic [DW-1:0] rd0;
  logic [7:0]    ec0;

  dmem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .err_count(err_count));

  dmem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_write(w0),
    .req_addr(a0), .req_wdata(d0), .req_ready(r0),
    .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(re0), .err_count(ec0));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  cnt;
    int unsigned acc;
  } exp_t;

  exp_t          q[$];
  exp_t          me;
  logic [31:0]   ref_mem [int];
  int            ref_errs = 0;
  int            total = 0;
  int            bad = 0;
  int unsigned   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Model: word memory with range check, errors counted and saturated at 255.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input bit track);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (track) begin
      e.acc = cyc;
      if ((a >> AW) != 0) begin
        if (ref_errs < 255) ref_errs++;
        e.rdata = 32'd0;
        e.err   = 1'b1;
      end else begin
        e.err = 1'b0;
        if (w) begin
          ref_mem[int'(a)] = d;
          e.rdata = 32'd0;
        end else begin
          e.rdata = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'd0;
        end
      end
      e.cnt = 8'(ref_errs);
      q.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        if (q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          me = q.pop_front();
          check("rsp_rdata", rsp_rdata, me.rdata);
          check("rsp_err", 32'(rsp_err), 32'(me.err));
          check("err_count", 32'(err_count), 32'(me.cnt));
          check("rsp_latency", cyc - me.acc, LAT + 1);
        end
      end else begin
        check("idle_rdata", rsp_rdata, 32'd0);
        check("idle_err", 32'(rsp_err), 32'd0);
      end
    end
  end

  initial begin
    int          n;
    int unsigned accs[$];
    int          widths[$];
    int          run;
    logic [31:0] a;

    // Reset and release
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    #1 check("release_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 check("ready_after_edge", 32'(req_ready), 32'd1);

    for (int i = 0; i < 16; i++) issue(1'b1, 32'(i), $urandom, 1'b1);
    issue(1'b1, 32'h05, 32'hDEADBEEF, 1'b1);
    issue(1'b0, 32'h05, 32'h0, 1'b1);
    issue(1'b1, 32'h100, 32'hBAD0BAD0, 1'b1);
    issue(1'b0, 32'h00, 32'h0, 1'b1);
    drain();
    check("err_count_one", 32'(err_count), 32'd1);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 4) == 0) a = $urandom | 32'h100;
      else a = 32'($urandom_range(0, 15));
      issue(1'($urandom_range(0, 1)), a, $urandom, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    // Reset one cycle after accept drops the pending store
    issue(1'b1, 32'h0A, 32'h12345678, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    ref_errs = 0;
    @(negedge clk);
    check("midrst_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    #1 check("midrst_release_ready", 32'(req_ready), 32'd0);
    check("midrst_err_count", 32'(err_count), 32'd0);
    issue(1'b0, 32'h0A, 32'h0, 1'b1);
    drain();

    for (int i = 0; i < 300; i++) issue(1'($urandom_range(0, 1)), 32'h100 + 32'(i), $urandom, 1'b1);
    drain();
    check("sat_count", 32'(err_count), 32'd255);
    issue(1'b1, 32'hFFFF_FFFF, 32'h1, 1'b1);
    drain();
    check("sat_hold", 32'(err_count), 32'd255);

    // LATENCY=0 instance: store, then held-valid back-to-back loads
    @(negedge clk);
    v0 = 1'b1; w0 = 1'b1; a0 = 32'h03; d0 = 32'hA5A50003;
    n = 0;
    while (!r0 && n < 50) begin @(negedge clk); n++; end
    check("b2b_store_ready", 32'(r0), 32'd1);
    @(posedge clk);
    #1 v0 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!r0 && n < 50) begin @(negedge clk); n++; end
    v0 = 1'b1; w0 = 1'b0;
    run = 0;
    for (int i = 0; i < 12; i++) begin
      if (rv0) begin
        run++;
        check("b2b_rdata", rd0, 32'hA5A50003);
        if (accs.size() > 0) check("b2b_latency", cyc - accs[accs.size()-1], 32'd1);
      end else if (run != 0) begin
        widths.push_back(run);
        run = 0;
      end
      if (r0) accs.push_back(cyc + 1);
      @(negedge clk);
    end
    v0 = 1'b0;
    if (run != 0) widths.push_back(run);
    check("b2b_accepts", 32'(accs.size() >= 2), 32'd1);
    for (int i = 1; i < accs.size(); i++) check("b2b_spacing", accs[i] - accs[i-1], 32'd3);
    check("b2b_pulses", 32'(widths.size() >= 2), 32'd1);
    foreach (widths[i]) check("b2b_pulse_width", 32'(widths[i]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=done", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Word-addressed data-memory responder that answers load/store requests issued by the pipelined datapath's MEM stage. It sits on the memory side of the datapath's data-memory port. It accepts one request at a time through a valid/ready handshake, inserts a programmable number of wait states, and then commits the write or performs the read. It returns a single-cycle response carrying the read data and an out-of-range error flag.

## Interface
- ADDR_W, default 8: word-address width; storage depth is 2^ADDR_W 32-bit words.
- DATA_W, default 32: data word width; must match the datapath word.
- LATENCY, default 2: wait-state cycles between request accept and access; legal range 0..15.
- clk  input  1  rising-edge clock shared with the datapath.
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
- req_valid  input  1  request present; must hold stable until accepted.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  word address (ALU result).
- req_wdata  input  DATA_W  store data (rt operand).
- req_ready  output  1  responder can accept a request this cycle.
- rsp_valid  output  1  one-cycle pulse: response fields valid.
- rsp_rdata  output  DATA_W  load data; 0 for stores and errors.
- rsp_err  output  1  request address out of range.
- err_count  output  8  saturating count of errored requests since reset.

## Operation
- Storage: 2^ADDR_W x DATA_W array. It is not cleared by reset, and its contents survive reset.
- Range check: an address is out of range when req_addr[31:ADDR_W] is nonzero.
  - Errored store: no array write.
  - Errored load: rsp_rdata = 0.
  - Any errored request: err_count increments, saturating at 255.
- States: IDLE, WAIT, RESP, all registered.
- IDLE:
  - req_ready = 1.
  - On an edge with req_valid=1, latch addr, wdata and write, load the wait counter with LATENCY, and go to WAIT.
- WAIT:
  - req_ready = 0.
  - Each edge with counter != 0 decrements the counter.
  - On the edge with counter == 0, perform the access and go to RESP:
    - a store commits to the array at that edge;
    - a load registers the array word into rsp_rdata.
  - At that same edge, register rsp_valid = 1 and rsp_err.
- RESP:
  - rsp_valid = 1 for exactly this cycle; req_ready = 0.
  - On the next edge go to IDLE, clear rsp_valid, and clear rsp_rdata and rsp_err to 0.
- There is no response backpressure. The datapath must capture the response in the rsp_valid cycle.
- Requests are strictly in order, and only one can be outstanding.

## Timing
- Reset (rst_n=0, asynchronous):
  - state = IDLE, counter = 0;
  - req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, err_count = 0.
- req_ready is registered. It rises at the first clk edge after rst_n deasserts, so no request is accepted in the release cycle.
- Accept edge E0 is the edge with req_valid & req_ready.
  - req_ready is low from E0 to E0+LATENCY+2.
  - rsp_valid is high between edges E0+LATENCY+1 and E0+LATENCY+2.
  - req_ready is high again after E0+LATENCY+2.
- Load-to-data latency is LATENCY+1 cycles. Back-to-back throughput is one request per LATENCY+3 cycles.
- LATENCY=0: WAIT lasts one cycle, and the response appears after E0+1.
- Store followed by a load to the same address returns the new data, because the store commits before the load is accepted.
- Reset mid-operation:
  - a pending request in WAIT is dropped, and its store is not committed;
  - a store already committed (state RESP) persists.
- req_valid asserted while req_ready = 0 is ignored; the requester holds it until accepted.
- err_count at 255 stays 255 on further errors.

## Test plan
- Reset release: rst_n low, then high → req_ready 0 in the release cycle and 1 after the next edge; all response outputs 0.
- Store then load, LATENCY=2:
  - store addr 0x05 data 0xDEADBEEF → rsp_valid pulse 3 cycles after accept, rsp_err 0, rsp_rdata 0.
  - load addr 0x05 → rsp_rdata 0xDEADBEEF 3 cycles after accept.
- Out of range, ADDR_W=8:
  - store to addr 0x100 → rsp_err 1, err_count 1.
  - load addr 0x00 → returns its prior value, not the errored data.
- LATENCY=0 back-to-back: two loads with req_valid held high → accepts spaced exactly 3 cycles apart, each rsp_valid exactly 1 cycle wide.
- Reset mid-WAIT: store 0x12345678 to addr 0x0A, assert rst_n low one cycle after accept → later load of 0x0A returns its pre-store value; err_count 0.
- Saturation: 300 errored requests → err_count reads 255 and holds.
